spi_xform_slave: RTL and testbench
==================================

SPI_XFORM_SLAVE -- requirements
Module: spi_xform_slave

Interface
REQ-001 Parameter DW, default 8, meaning frame width in bits; legal range 4..32.
REQ-002 Parameter STREAM, default 1, meaning 1 returns to RX after each TX frame, 0 parks in DONE until ss high.
REQ-003 Parameter CNTW, default 16, meaning frame_cnt width.
REQ-004 clock  input  1  system clock; all logic is synchronous to its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sck  input  1  SPI clock from master, asynchronous to clock, idle low (mode 0).
REQ-007 ss  input  1  active-low slave select, asynchronous.
REQ-008 mosi  input  1  serial data in, MSB first.
REQ-009 mode  input  2  transform select: 00 reverse, 01 passthrough, 10 invert, 11 reverse+invert.
REQ-010 miso  output  1  serial data out, MSB first, registered, idles 1.
REQ-011 frame_done  output  1  one-clock pulse when a TX frame completes.
REQ-012 frame_cnt  output  CNTW  count of completed TX frames since reset.
REQ-013 busy  output  1  high in RX, TX or DONE.

Function
REQ-014 sck, ss and mosi SHALL each pass through a 2-flop synchroniser before use; sck rise/fall SHALL be detected from the synchronised value (one-clock pulse each).
REQ-015 Supported sck frequency SHALL be at most clock/4; behaviour above that is undefined.
REQ-016 States SHALL be IDLE, RX, TX, DONE.
REQ-017 IDLE: miso=1, bit counter=0, shift register=0; synchronised ss low -> RX, and mode SHALL be latched at this transition.
REQ-018 RX: on each sck rise, shift mosi into LSB of a DW-bit register and increment counter; miso held 1.
REQ-019 On the DW-th RX rise, counter SHALL wrap to 0, the latched transform SHALL be applied to the assembled word into a TX register, and state SHALL go to TX.
REQ-020 TX: on each sck fall, miso SHALL drive the next TX bit, MSB first; the first fall after entering TX drives bit DW-1.
REQ-021 TX: sck rises are counted; on the DW-th TX rise, frame_done SHALL pulse the following clock, frame_cnt SHALL increment (wraps at 2^CNTW), and state SHALL go to RX (STREAM=1) or DONE (STREAM=0).
REQ-022 On return to RX, miso SHALL return to 1 at the next sck fall; mode is NOT re-latched mid-select.
REQ-023 DONE: miso=1, all sck edges ignored.
REQ-024 Synchronised ss high in any state SHALL force IDLE on the next clock, abandoning any partial frame without frame_done or frame_cnt change; ss high has priority over a coincident sck edge.
REQ-025 Reverse: out[i]=in[DW-1-i]; invert: out=~in; reverse+invert: invert applied after reverse.
REQ-026 An illegal state encoding SHALL recover to IDLE.

Reset
REQ-027 reset_n low SHALL asynchronously force: state IDLE, miso=1, frame_done=0, frame_cnt=0, busy=0, counters, shift/TX registers and synchronisers to 0 (sck sync) and 1 (ss sync).
REQ-028 Reset release mid-transaction SHALL leave the block in IDLE until ss is seen high then low again.

Structure
REQ-029 Package spi_xform_pkg SHALL hold the state enum and the mode encodings (MODE_REV, MODE_PASS, MODE_INV, MODE_REVINV).
REQ-030 One sub-module spi_sync_edge SHALL implement the 2-flop synchroniser plus rise/fall pulse generation, instantiated for sck; ss and mosi use the synchroniser only.
REQ-031 The transform SHALL be a pure combinational function local to spi_xform_slave.

Verification
REQ-032 DW=8, mode 00, send 0x01 -> miso returns 0x80, frame_done one pulse, frame_cnt=1.
REQ-033 DW=8, mode 10, send 0xA5 -> miso returns 0x5A.
REQ-034 DW=8, STREAM=1, mode 00, one select: 0x0F, then 0x33 -> miso 0xF0 then 0xCC, frame_cnt=2.
REQ-035 ss raised after 3 RX bits -> IDLE, miso=1, no frame_done; next full frame 0x01 -> 0x80.
REQ-036 reset_n pulsed low during TX bit 4 -> all outputs at reset values immediately; frame_cnt stays 0.
REQ-037 DW=16, mode 00, send 0x1234 -> miso 0x2C48; STREAM=0, extra 16 sck cycles -> miso stays 1, frame_cnt=1.

Source files
------------

// File: rtl/spi_xform_pkg.sv
// rtl/spi_xform_pkg.sv - shared state and transform-mode encodings for the SPI transform slave
package spi_xform_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RX   = 2'd1,
      ST_TX   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] MODE_REV    = 2'b00;
   localparam logic [1:0] MODE_PASS   = 2'b01;
   localparam logic [1:0] MODE_INV    = 2'b10;
   localparam logic [1:0] MODE_REVINV = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchroniser with one-clock rise/fall pulses
module spi_sync_edge (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   // sr[0] metastable stage, sr[1] synchronised value, sr[2] previous synchronised value
   logic [2:0] sr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sr <= 3'b000;
      end else begin
         sr <= {sr[1:0], din};
      end
   end

   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_xform_slave.sv
// rtl/spi_xform_slave.sv - mode-0 SPI slave that receives a frame and returns it transformed
module spi_xform_slave
   import spi_xform_pkg::*;
#(
   parameter int DW     = 8,
   parameter int STREAM = 1,
   parameter int CNTW   = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            sck,
   input  logic            ss,
   input  logic            mosi,
   input  logic [1:0]      mode,
   output logic            miso,
   output logic            frame_done,
   output logic [CNTW-1:0] frame_cnt,
   output logic            busy
);

   localparam int           CW   = $clog2(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   function automatic logic [DW-1:0] xform(input logic [DW-1:0] d, input logic [1:0] m);
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) begin
         r[i] = d[DW-1-i];
      end
      case (m)
         MODE_REV:  xform = r;
         MODE_PASS: xform = d;
         MODE_INV:  xform = ~d;
         default:   xform = ~r;
      endcase
   endfunction

   state_t          state, state_nxt;
   logic            sck_rise, sck_fall;
   logic [1:0]      ss_sr, mosi_sr, ss_vld;
   logic            ss_s, mosi_s;
   logic            armed, armed_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [DW-1:0]   sh, sh_nxt, sh_w, tx, tx_nxt;
   logic            miso_nxt, done_nxt;
   logic [CNTW-1:0] fcnt_nxt;
   logic [1:0]      mode_q, mode_nxt;

   spi_sync_edge u_sck_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (sck),
      .rise    (sck_rise),
      .fall    (sck_fall)
   );

   assign ss_s   = ss_sr[1];
   assign mosi_s = mosi_sr[1];
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ss_vld marks when ss_s reflects a real sample, so the reset value of the
   // ss synchroniser can never arm a selection that started before reset release.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sh_nxt    = sh;
      sh_w      = {sh[DW-2:0], mosi_s};
      tx_nxt    = tx;
      miso_nxt  = miso;
      done_nxt  = 1'b0;
      fcnt_nxt  = frame_cnt;
      mode_nxt  = mode_q;
      armed_nxt = armed | (ss_vld[1] & ss_s);
      if (ss_s) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
         sh_nxt    = '0;
         tx_nxt    = '0;
         miso_nxt  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               miso_nxt = 1'b1;
               cnt_nxt  = '0;
               sh_nxt   = '0;
               if (armed) begin
                  state_nxt = ST_RX;
                  mode_nxt  = mode;
               end
            end
            ST_RX: begin
               if (sck_fall) begin
                  miso_nxt = 1'b1;
               end
               if (sck_rise) begin
                  sh_nxt = sh_w;
                  if (cnt == LAST) begin
                     cnt_nxt   = '0;
                     tx_nxt    = xform(sh_w, mode_q);
                     state_nxt = ST_TX;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            ST_TX: begin
               if (sck_fall) begin
                  miso_nxt = tx[DW-1];
                  tx_nxt   = {tx[DW-2:0], 1'b0};
               end
               if (sck_rise) begin
                  if (cnt == LAST) begin
                     cnt_nxt   = '0;
                     done_nxt  = 1'b1;
                     fcnt_nxt  = frame_cnt + 1'b1;
                     state_nxt = (STREAM != 0) ? ST_RX : ST_DONE;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               miso_nxt = 1'b1;
            end
            default: begin
               state_nxt = ST_IDLE;
               miso_nxt  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ss_sr      <= 2'b11;
         mosi_sr    <= 2'b00;
         ss_vld     <= 2'b00;
         armed      <= 1'b0;
         cnt        <= '0;
         sh         <= '0;
         tx         <= '0;
         miso       <= 1'b1;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         mode_q     <= MODE_REV;
      end else begin
         ss_sr      <= {ss_sr[0], ss};
         mosi_sr    <= {mosi_sr[0], mosi};
         ss_vld     <= {ss_vld[0], 1'b1};
         armed      <= armed_nxt;
         cnt        <= cnt_nxt;
         sh         <= sh_nxt;
         tx         <= tx_nxt;
         miso       <= miso_nxt;
         frame_done <= done_nxt;
         frame_cnt  <= fcnt_nxt;
         mode_q     <= mode_nxt;
      end
   end

endmodule

// File: tb/tb_spi_xform_slave.sv
// tb/tb_spi_xform_slave.sv - directed table-driven bench for spi_xform_slave (DW=8 stream and DW=16 park)
module tb_spi_xform_slave;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  mode;
   logic        sck_a, ss_a, mosi_a, miso_a, frame_done_a, busy_a;
   logic        sck_b, ss_b, mosi_b, miso_b, frame_done_b, busy_b;
   logic [15:0] frame_cnt_a, frame_cnt_b;

   int n_vec = 0;
   int n_bad = 0;
   int pulses_a = 0;
   int pulses_b = 0;

   spi_xform_slave #(.DW(8), .STREAM(1), .CNTW(16)) dut_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .sck        (sck_a),
      .ss         (ss_a),
      .mosi       (mosi_a),
      .mode       (mode),
      .miso       (miso_a),
      .frame_done (frame_done_a),
      .frame_cnt  (frame_cnt_a),
      .busy       (busy_a)
   );

   spi_xform_slave #(.DW(16), .STREAM(0), .CNTW(16)) dut_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .sck        (sck_b),
      .ss         (ss_b),
      .mosi       (mosi_b),
      .mode       (mode),
      .miso       (miso_b),
      .frame_done (frame_done_b),
      .frame_cnt  (frame_cnt_b),
      .busy       (busy_b)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (frame_done_a) pulses_a++;
      if (frame_done_b) pulses_b++;
   end

   typedef struct {
      int          w;
      logic [1:0]  md;
      logic [15:0] din;
      logic [15:0] dout;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_ss(input int w, input logic v);
      if (w == 0) ss_a = v; else ss_b = v;
   endtask

   // one sck period: drive mosi, sample miso just before the rise
   task automatic cycle(input int w, input logic b, output logic m);
      if (w == 0) mosi_a = b; else mosi_b = b;
      #40;
      m = (w == 0) ? miso_a : miso_b;
      if (w == 0) sck_a = 1'b1; else sck_b = 1'b1;
      #40;
      if (w == 0) sck_a = 1'b0; else sck_b = 1'b0;
   endtask

   task automatic frame(input int w, input int n, input logic [15:0] d, output logic [15:0] r);
      logic m;
      r = '0;
      for (int i = n - 1; i >= 0; i--) cycle(w, d[i], m);
      for (int i = n - 1; i >= 0; i--) begin
         cycle(w, 1'b0, m);
         r[i] = m;
      end
   endtask

   initial begin
      logic [15:0] rx;
      logic        m;
      logic        all_ones;
      int          exp_a, exp_b, p0;

      vt[0] = '{0, 2'b00, 16'h0001, 16'h0080};
      vt[1] = '{0, 2'b10, 16'h00A5, 16'h005A};
      vt[2] = '{0, 2'b01, 16'h003C, 16'h003C};
      vt[3] = '{0, 2'b11, 16'h00C5, 16'h005C};
      vt[4] = '{1, 2'b00, 16'h1234, 16'h2C48};
      vt[5] = '{1, 2'b01, 16'hBEEF, 16'hBEEF};
      vt[6] = '{1, 2'b10, 16'h00FF, 16'hFF00};
      vt[7] = '{1, 2'b11, 16'h8001, 16'h7FFE};

      reset_n = 1'b0;
      mode = 2'b00;
      sck_a = 1'b0; ss_a = 1'b1; mosi_a = 1'b0;
      sck_b = 1'b0; ss_b = 1'b1; mosi_b = 1'b0;
      exp_a = 0; exp_b = 0;
      #17;
      check("rst_miso_a", {31'd0, miso_a}, 32'd1);
      check("rst_done_a", {31'd0, frame_done_a}, 32'd0);
      check("rst_cnt_a", {16'd0, frame_cnt_a}, 32'd0);
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_miso_b", {31'd0, miso_b}, 32'd1);
      check("rst_busy_b", {31'd0, busy_b}, 32'd0);
      reset_n = 1'b1;
      #100;

      for (int k = 0; k < 8; k++) begin
         int w, n;
         w = vt[k].w;
         n = (w == 0) ? 8 : 16;
         p0 = (w == 0) ? pulses_a : pulses_b;
         mode = vt[k].md;
         set_ss(w, 1'b0);
         #40;
         frame(w, n, vt[k].din, rx);
         #40;
         check($sformatf("vec%0d_data", k), {16'd0, rx}, {16'd0, vt[k].dout});
         check($sformatf("vec%0d_pulse", k), ((w == 0) ? pulses_a : pulses_b) - p0, 32'd1);
         if (w == 0) exp_a++; else exp_b++;
         check($sformatf("vec%0d_cnt", k), {16'd0, (w == 0) ? frame_cnt_a : frame_cnt_b},
               (w == 0) ? exp_a : exp_b);
         check($sformatf("vec%0d_busy", k), {31'd0, (w == 0) ? busy_a : busy_b}, 32'd1);
         set_ss(w, 1'b1);
         #80;
         check($sformatf("vec%0d_idle", k), {31'd0, (w == 0) ? busy_a : busy_b}, 32'd0);
      end

      // two frames in one selection on the streaming instance
      mode = 2'b00;
      p0 = pulses_a;
      ss_a = 1'b0;
      #40;
      frame(0, 8, 16'h000F, rx);
      check("stream_f1", {16'd0, rx}, 32'h00F0);
      frame(0, 8, 16'h0033, rx);
      check("stream_f2", {16'd0, rx}, 32'h00CC);
      #40;
      exp_a += 2;
      check("stream_cnt", {16'd0, frame_cnt_a}, exp_a);
      check("stream_pulses", pulses_a - p0, 32'd2);
      ss_a = 1'b1;
      #80;

      // partial frame abandoned by ss, then a clean frame
      p0 = pulses_a;
      ss_a = 1'b0;
      #40;
      for (int i = 0; i < 3; i++) cycle(0, 1'b1, m);
      ss_a = 1'b1;
      #60;
      check("abort_busy", {31'd0, busy_a}, 32'd0);
      check("abort_miso", {31'd0, miso_a}, 32'd1);
      check("abort_pulses", pulses_a - p0, 32'd0);
      check("abort_cnt", {16'd0, frame_cnt_a}, exp_a);
      ss_a = 1'b0;
      #40;
      frame(0, 8, 16'h0001, rx);
      #40;
      exp_a++;
      check("after_abort_data", {16'd0, rx}, 32'h0080);
      check("after_abort_cnt", {16'd0, frame_cnt_a}, exp_a);
      ss_a = 1'b1;
      #80;

      // DW=16 parks in DONE: extra clocks return only ones
      mode = 2'b00;
      ss_b = 1'b0;
      #40;
      frame(1, 16, 16'h1234, rx);
      exp_b++;
      check("park_data", {16'd0, rx}, 32'h2C48);
      all_ones = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cycle(1, 1'b1, m);
         if (m !== 1'b1) all_ones = 1'b0;
      end
      #40;
      check("park_miso_ones", {31'd0, all_ones}, 32'd1);
      check("park_cnt", {16'd0, frame_cnt_b}, exp_b);
      check("park_busy", {31'd0, busy_b}, 32'd1);
      ss_b = 1'b1;
      #80;

      // reset asserted during TX bit 4, released while ss still low
      mode = 2'b01;
      ss_a = 1'b0;
      #40;
      for (int i = 7; i >= 0; i--) cycle(0, 1'b0, m);
      for (int i = 0; i < 4; i++) cycle(0, 1'b0, m);
      p0 = pulses_a;
      reset_n = 1'b0;
      #1;
      check("midrst_miso", {31'd0, miso_a}, 32'd1);
      check("midrst_done", {31'd0, frame_done_a}, 32'd0);
      check("midrst_cnt", {16'd0, frame_cnt_a}, 32'd0);
      check("midrst_busy", {31'd0, busy_a}, 32'd0);
      check("midrst_cnt_b", {16'd0, frame_cnt_b}, 32'd0);
      #29;
      reset_n = 1'b1;
      all_ones = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 1'b1, m);
         if (m !== 1'b1) all_ones = 1'b0;
      end
      check("postrst_miso_ones", {31'd0, all_ones}, 32'd1);
      check("postrst_busy", {31'd0, busy_a}, 32'd0);
      check("postrst_cnt", {16'd0, frame_cnt_a}, 32'd0);
      check("postrst_pulses", pulses_a - p0, 32'd0);
      ss_a = 1'b1;
      #80;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
